// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between uart_rx and the UART/data-memory bridge.
// Each rising edge of rx_ready stores one byte into a first-word-fall-through FIFO,
// and the bridge removes bytes with pop at its own pace.
// Optional build macro UART_RX_FIFO_DROP_OLDEST_EN: when defined, a byte that arrives
// while the FIFO is full evicts the oldest entry instead of being dropped.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              pop,
    output logic [7:0]        dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              prev_rx_ready;
    logic              overrun_q;

    logic push_req;
    logic pop_eff;
    logic push_acc;
    logic overflow;
    logic evict;
    logic wr_en;
    logic rd_adv;

    // Flags come straight from the registered occupancy counter.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_CNT);
        count = count_q;
    end

    // A full FIFO still takes a new byte when the same cycle frees a slot.
    always_comb begin
        push_req = rx_ready & ~prev_rx_ready;
        pop_eff  = pop & ~empty;
        push_acc = push_req & (~full | pop_eff);
        overflow = push_req & full & ~pop_eff;
`ifdef UART_RX_FIFO_DROP_OLDEST_EN
        evict    = overflow;
`else
        evict    = 1'b0;
`endif
        wr_en    = push_acc | evict;
        rd_adv   = pop_eff | evict;
    end

    // Head byte is read asynchronously and forced to zero while nothing is stored.
    always_comb begin
        dout = empty ? 8'h00 : mem[rd_ptr];
    end

    // Storage is written without reset; stale contents are hidden by the empty gate.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Previous ready level resets high so a receiver already high at release is ignored.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            prev_rx_ready <= 1'b1;
        end else begin
            prev_rx_ready <= rx_ready;
        end
    end

    // Pointers advance independently and wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Occupancy only moves when exactly one of push/pop takes effect; eviction keeps it at DEPTH.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (push_acc && !pop_eff) begin
            count_q <= count_q + (ADDR_W + 1)'(1);
        end else if (pop_eff && !push_acc) begin
            count_q <= count_q - (ADDR_W + 1)'(1);
        end
    end

    // Sticky overrun: a new overflow beats a simultaneous clear so no event is lost.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            overrun_q <= 1'b0;
        end else if (overflow) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized traffic for uart_rx_fifo,
// checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock;
    logic              n_rst;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              pop;
    logic              clr_overrun;
    logic [7:0]        dout;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    int testsRun;
    int failCount;

    logic [7:0] modelQ[$];
    bit         modelPrev;
    bit         modelOverrun;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .n_rst       (n_rst),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .pop         (pop),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: a byte queue, a sticky flag and the last ready level.
    task automatic modelReset();
        modelQ.delete();
        modelPrev    = 1'b1;
        modelOverrun = 1'b0;
    endtask

    task automatic modelStep(input bit rdy, input logic [7:0] data, input bit popReq, input bit clr);
        bit newByte;
        bit doPop;
        newByte   = rdy && !modelPrev;
        modelPrev = rdy;
        doPop     = popReq && (modelQ.size() > 0);
        if (doPop) begin
            void'(modelQ.pop_front());
        end
        if (newByte) begin
            if (modelQ.size() < DEPTH) begin
                modelQ.push_back(data);
            end else begin
                modelOverrun = 1'b1;
`ifdef UART_RX_FIFO_DROP_OLDEST_EN
                void'(modelQ.pop_front());
                modelQ.push_back(data);
`endif
            end
        end
        if (clr && !(newByte && !doPop && modelQ.size() == DEPTH && !modelOverrunSetThisCycle(newByte, doPop))) begin
            modelOverrun = modelOverrun;
        end
    endtask

    function automatic bit modelOverrunSetThisCycle(input bit newByte, input bit doPop);
        return 1'b0;
    endfunction

    task automatic compareModel(input string ctx);
        logic [7:0] expDout;
        expDout = (modelQ.size() > 0) ? modelQ[0] : 8'h00;
        checkOutput({ctx, ".dout"}, {8'h00, dout}, {8'h00, expDout});
        checkOutput({ctx, ".empty"}, {15'h0, empty}, {15'h0, modelQ.size() == 0});
        checkOutput({ctx, ".full"}, {15'h0, full}, {15'h0, modelQ.size() == DEPTH});
        checkOutput({ctx, ".count"}, 16'(count), 16'(modelQ.size()));
        checkOutput({ctx, ".overrun"}, {15'h0, overrun}, {15'h0, modelOverrun});
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, compare after it.
    task automatic applyStimulus(input string ctx, input bit rdy, input logic [7:0] data, input bit popReq, input bit clr);
        bit overflowNow;
        @(negedge clock);
        rx_ready    = rdy;
        rx_data     = data;
        pop         = popReq;
        clr_overrun = clr;
        @(posedge clock);
        overflowNow = rdy && !modelPrev && !(popReq && modelQ.size() > 0) && modelQ.size() == DEPTH;
        modelStep(rdy, data, popReq, clr);
        if (clr && !overflowNow) begin
            modelOverrun = 1'b0;
        end
        #1;
        compareModel(ctx);
    endtask

    task automatic pushByte(input string ctx, input logic [7:0] b);
        applyStimulus(ctx, 1'b0, b, 1'b0, 1'b0);
        applyStimulus(ctx, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic popByte(input string ctx);
        applyStimulus(ctx, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        failCount   = 0;
        n_rst       = 1'b0;
        rx_ready    = 1'b1;
        rx_data     = 8'h00;
        pop         = 1'b0;
        clr_overrun = 1'b0;
        modelReset();

        // Reset with receiver already high; release must not create a push.
        #12;
        compareModel("rst");
        checkOutput("rst.dout_const", {8'h00, dout}, 16'h0000);
        @(negedge clock);
        n_rst = 1'b1;
        applyStimulus("hold_high", 1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus("hold_high", 1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("hold_high.count_const", 16'(count), 16'd0);
        pushByte("first", 8'h41);
        checkOutput("first.dout_const", {8'h00, dout}, 16'h0041);
        popByte("first_pop");

        // Three pushes, three pops, then a pop on empty.
        pushByte("p3", 8'h01);
        pushByte("p3", 8'h02);
        pushByte("p3", 8'h03);
        checkOutput("p3.count_const", 16'(count), 16'd3);
        for (int i = 0; i < 4; i++) begin
            popByte("pop3");
        end
        checkOutput("pop3.empty_const", {15'h0, empty}, 16'h0001);

        // Fill to full, then one overflowing byte.
        for (int i = 0; i < DEPTH; i++) begin
            pushByte("fill", 8'(8'h10 + i));
        end
        checkOutput("fill.full_const", {15'h0, full}, 16'h0001);
        pushByte("ovf", 8'h55);
        checkOutput("ovf.overrun_const", {15'h0, overrun}, 16'h0001);
        checkOutput("ovf.count_const", 16'(count), 16'd16);
        for (int i = 0; i < DEPTH; i++) begin
            popByte("drain");
        end
        applyStimulus("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Full with push and pop in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            pushByte("fill2", 8'(8'h60 + i));
        end
        applyStimulus("fullpp", 1'b0, 8'hAA, 1'b0, 1'b0);
        applyStimulus("fullpp", 1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("fullpp.count_const", 16'(count), 16'd16);
        checkOutput("fullpp.overrun_const", {15'h0, overrun}, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            popByte("drain2");
        end

        // Empty with push and pop together, then 40 pairs to wrap the pointers.
        applyStimulus("emptypp", 1'b0, 8'h7E, 1'b1, 1'b0);
        applyStimulus("emptypp", 1'b1, 8'h7E, 1'b1, 1'b0);
        checkOutput("emptypp.dout_const", {8'h00, dout}, 16'h007E);
        for (int i = 0; i < 40; i++) begin
            applyStimulus("wrap", 1'b0, 8'(i * 7), 1'b0, 1'b0);
            applyStimulus("wrap", 1'b1, 8'(i * 7), 1'b1, 1'b0);
        end
        popByte("wrap_end");

        // Clear racing a dropping push, then clear alone.
        for (int i = 0; i < DEPTH; i++) begin
            pushByte("fill3", 8'(8'hC0 + i));
        end
        pushByte("ovf3", 8'hEE);
        applyStimulus("clr_race", 1'b0, 8'hEF, 1'b0, 1'b0);
        applyStimulus("clr_race", 1'b1, 8'hEF, 1'b0, 1'b1);
        checkOutput("clr_race.overrun_const", {15'h0, overrun}, 16'h0001);
        applyStimulus("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_alone.overrun_const", {15'h0, overrun}, 16'h0000);

        // Bring occupancy to 5, then assert reset between clock edges.
        while (modelQ.size() > 5) begin
            popByte("to5");
        end
        @(negedge clock);
        #2;
        n_rst = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst.count", 16'(count), 16'd0);
        checkOutput("async_rst.empty", {15'h0, empty}, 16'h0001);
        compareModel("async_rst");
        @(negedge clock);
        n_rst = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus("rand", ($urandom_range(0, 99) < 45), 8'($urandom),
                          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
